button_repeat_unit: RTL and testbench
=====================================

Name: button_repeat_unit

Overview:
- Parametrised input conditioner for NUM_BTN player buttons.
- Per channel: synchroniser, debounce, press/release edge pulses, and hold-to-repeat (delayed auto-shift, then fixed-rate repeat).
- Sits between the raw board buttons and the piece-movement logic, replacing direct button wiring into the cell store.
- All timing is in clk_25_175 cycles, so move rate is independent of the game tick.

Parameters:
- NUM_BTN, 3: number of independent button channels.
- SYNC_STAGES, 2: flip-flop synchroniser depth, minimum 2.
- DEBOUNCE_CYCLES, 250000: consecutive disagreeing synced samples needed before the stable level flips (about 10 ms); minimum 1.
- DAS_CYCLES, 4000000: cycles from press pulse to first repeat pulse; minimum 1.
- ARR_CYCLES, 1000000: cycles between subsequent repeat pulses; minimum 1.
- ACTIVE_LOW, 0: 1 means the raw input is inverted before synchronisation.

Ports:
- clk_25_175  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  NUM_BTN  asynchronous raw button inputs.
- repeat_en  in  NUM_BTN  per-channel auto-repeat enable.
- pause  in  1  freezes repeat timing and suppresses repeat pulses; debounce keeps running.
- btn_level  out  NUM_BTN  debounced stable level.
- btn_press  out  NUM_BTN  1-cycle pulse on a debounced press and on each repeat.
- btn_release  out  NUM_BTN  1-cycle pulse on a debounced release.
- btn_is_repeat  out  NUM_BTN  qualifies btn_press: 1 = repeat pulse, 0 = initial press.

Behaviour:
- Interface: one clock, clk_25_175. reset is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - Synchroniser flops, counters and stable levels all 0.
  - Every channel FSM in IDLE.
- Channels are fully independent. Simultaneous events on different channels never interact.
- Synchroniser: s = last stage of a SYNC_STAGES-deep chain on (btn_raw XOR ACTIVE_LOW).
- Debounce, per cycle:
  - If s == level: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: level <= s, dcnt <= 0, and a rising or falling event is generated.
  - Else: dcnt <= dcnt + 1.
  - Any agreeing sample clears dcnt, so a bouncing input never flips level.
- Latency: a clean raw edge at cycle 0 changes btn_level and pulses btn_press or btn_release in cycle SYNC_STAGES + DEBOUNCE_CYCLES. All outputs are registered.
- Repeat FSM states, per channel, with counter rcnt:
  - IDLE: on rising event, pulse press (is_repeat = 0) and rcnt <= 0. Go to DELAY if repeat_en = 1, else HELD.
  - DELAY: when rcnt == DAS_CYCLES-1, pulse press with is_repeat = 1, rcnt <= 0, go to REPEAT. Otherwise rcnt++.
  - REPEAT: when rcnt == ARR_CYCLES-1, pulse press with is_repeat = 1 and rcnt <= 0. Otherwise rcnt++.
  - HELD: no repeats; rcnt is held at 0.
- Result: the first repeat comes exactly DAS_CYCLES cycles after the initial press pulse, then one every ARR_CYCLES cycles.
- Falling event, from any state: pulse btn_release, go to IDLE, rcnt <= 0. A release in the same cycle as a due repeat wins; no press pulse is emitted.
- repeat_en:
  - Deasserting it in DELAY or REPEAT moves the channel to HELD next cycle.
  - Asserting it in HELD does not restart repeating; a new press is required.
- pause = 1: rcnt holds its value and due repeat pulses are not emitted. The count resumes from the held value when pause drops. Initial press and release pulses are never suppressed.
- Reset mid-hold: state is cleared. A button still held after reset produces a fresh press pulse SYNC_STAGES + DEBOUNCE_CYCLES cycles after reset deasserts.
- Counter widths: clog2 of the maximum count, minimum 1 bit. Counters never wrap; equality compare only.

Decomposition:
- Shared package (tetris_pkg):
  - 2-bit repeat state enum: IDLE, DELAY, REPEAT, HELD.
  - Width helper function cnt_width(n).
  - Default timing constants for 25.175 MHz.
- One sub-module: btn_channel, which holds the synchroniser, debounce and repeat FSM for a single bit. The top generates NUM_BTN instances and concatenates their outputs.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, DAS_CYCLES=10, ARR_CYCLES=3, NUM_BTN=3):
1. btn_raw[0] rises clean at cycle 0 and is held, repeat_en = 1 -> btn_press[0] at cycle 6 (is_repeat = 0), then at 16, 19, 22, 25 (is_repeat = 1); btn_level[0] = 1 from cycle 6.
2. btn_raw[1] toggles every 2 cycles for 20 cycles, then held high -> exactly one btn_press[1], 6 cycles after the final rising edge; no release pulse.
3. Press with repeat_en = 0, hold 50 cycles, release -> one press at cycle 6, no repeats; btn_release when debounce completes, 6 cycles after the raw fall.
4. Hold btn 0 and assert pause during cycles 12–20 -> no pulses in that window. rcnt froze at 5, so the first repeat comes at cycle 25 (16 + 9 paused cycles), then 28.
5. Release btn 0 so the falling event lands on a due repeat cycle -> btn_release only, no press. Simultaneously press btn 2 -> its press pulse is unaffected.
6. Assert reset for 1 cycle while btn 0 is held in REPEAT -> all outputs 0 next cycle; a fresh press (is_repeat = 0) 6 cycles after reset deasserts.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and timing defaults for the button conditioning path.
// All cycle counts assume the 25.175 MHz pixel clock.
package tetris_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT,
      HELD
   } rpt_state_e;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 250000;
   localparam int DEF_DAS_CYCLES      = 4000000;
   localparam int DEF_ARR_CYCLES      = 1000000;

   // Bits needed to hold counts 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/button_repeat_unit_if.sv
// Bundle of raw button inputs, repeat controls and conditioned outputs.
// master drives the board side; slave is the conditioning unit.
interface button_repeat_unit_if #(
   parameter int NUM_BTN = 3
) ();

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] repeat_en;
   logic               pause;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_release;
   logic [NUM_BTN-1:0] btn_is_repeat;

   modport master (
      output btn_raw,
      output repeat_en,
      output pause,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_is_repeat
   );

   modport slave (
      input  btn_raw,
      input  repeat_en,
      input  pause,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_is_repeat
   );

endinterface

// File: rtl/button_repeat_unit_btn_channel.sv
// One button: synchroniser, debounce and the hold-to-repeat FSM.
// Every output is a flop; events from debounce feed the FSM in the same cycle.
module btn_channel
   import tetris_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int DAS_CYCLES      = DEF_DAS_CYCLES,
   parameter int ARR_CYCLES      = DEF_ARR_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clk_25_175,
   input  logic reset,
   input  logic raw_i,
   input  logic repeatEn_i,
   input  logic pause_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic isRepeat_o
);

   localparam int RPT_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
   localparam int DW      = cnt_width(DEBOUNCE_CYCLES);
   localparam int RW      = cnt_width(RPT_MAX);

   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DAS_LAST = RW'(DAS_CYCLES - 1);
   localparam logic [RW-1:0] ARR_LAST = RW'(ARR_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DW-1:0]          dbCnt_q;
   logic                   level_q;
   rpt_state_e             state_q;
   logic [RW-1:0]          rptCnt_q;
   logic                   press_q;
   logic                   release_q;
   logic                   isRepeat_q;

   logic syncBit;
   logic dbDone;
   logic riseEvt;
   logic fallEvt;
   logic rptDue;

   assign syncBit = sync_q[SYNC_STAGES-1];
   assign dbDone  = (syncBit != level_q) && (dbCnt_q == DB_LAST);
   assign riseEvt = dbDone & syncBit;
   assign fallEvt = dbDone & ~syncBit;
   assign rptDue  = (rptCnt_q == ((state_q == DELAY) ? DAS_LAST : ARR_LAST));

   // Any sample agreeing with the stable level restarts the count, so bounce never flips it.
   always_ff @(posedge clk_25_175) begin
      if (reset) begin
         sync_q  <= '0;
         dbCnt_q <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i ^ ACTIVE_LOW};
         if (syncBit == level_q) begin
            dbCnt_q <= '0;
         end else if (dbCnt_q == DB_LAST) begin
            level_q <= syncBit;
            dbCnt_q <= '0;
         end else begin
            dbCnt_q <= dbCnt_q + DW'(1);
         end
      end
   end

   // A release outranks a repeat falling due in the same cycle.
   always_ff @(posedge clk_25_175) begin
      if (reset) begin
         state_q    <= IDLE;
         rptCnt_q   <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         isRepeat_q <= 1'b0;
      end else begin
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         isRepeat_q <= 1'b0;
         if (fallEvt) begin
            release_q <= 1'b1;
            state_q   <= IDLE;
            rptCnt_q  <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (riseEvt) begin
                     press_q  <= 1'b1;
                     rptCnt_q <= '0;
                     state_q  <= repeatEn_i ? DELAY : HELD;
                  end
               end
               DELAY, REPEAT: begin
                  if (!repeatEn_i) begin
                     state_q  <= HELD;
                     rptCnt_q <= '0;
                  end else if (!pause_i) begin
                     if (rptDue) begin
                        press_q    <= 1'b1;
                        isRepeat_q <= 1'b1;
                        rptCnt_q   <= '0;
                        state_q    <= REPEAT;
                     end else begin
                        rptCnt_q <= rptCnt_q + RW'(1);
                     end
                  end
               end
               HELD: begin
                  rptCnt_q <= '0;
               end
               default: begin
                  state_q  <= IDLE;
                  rptCnt_q <= '0;
               end
            endcase
         end
      end
   end

   assign level_o    = level_q;
   assign press_o    = press_q;
   assign release_o  = release_q;
   assign isRepeat_o = isRepeat_q;

endmodule

// File: rtl/button_repeat_unit.sv
// Input conditioner for the player buttons: NUM_BTN independent channels
// between the raw board pins and the piece-movement logic.
module button_repeat_unit
   import tetris_pkg::*;
#(
   parameter int NUM_BTN         = 3,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int DAS_CYCLES      = DEF_DAS_CYCLES,
   parameter int ARR_CYCLES      = DEF_ARR_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clk_25_175,
   input  logic reset,
   button_repeat_unit_if.slave bus
);

   logic [NUM_BTN-1:0] levelVec;
   logic [NUM_BTN-1:0] pressVec;
   logic [NUM_BTN-1:0] releaseVec;
   logic [NUM_BTN-1:0] isRepeatVec;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      btn_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .DAS_CYCLES     (DAS_CYCLES),
         .ARR_CYCLES     (ARR_CYCLES),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_chan (
         .clk_25_175(clk_25_175),
         .reset     (reset),
         .raw_i     (bus.btn_raw[i]),
         .repeatEn_i(bus.repeat_en[i]),
         .pause_i   (bus.pause),
         .level_o   (levelVec[i]),
         .press_o   (pressVec[i]),
         .release_o (releaseVec[i]),
         .isRepeat_o(isRepeatVec[i])
      );
   end

   assign bus.btn_level     = levelVec;
   assign bus.btn_press     = pressVec;
   assign bus.btn_release   = releaseVec;
   assign bus.btn_is_repeat = isRepeatVec;

endmodule

// File: tb/tb_button_repeat_unit.sv
// Directed bench for button_repeat_unit with short timing (sync 2, debounce 4, DAS 10, ARR 3).
// Cycle k is the interval after posedge k; inputs set in cycle k are sampled at posedge k+1.
module tb_button_repeat_unit;

   typedef struct {
      int         cyc;
      logic [2:0] raw;
      logic [2:0] ren;
      logic       pause;
      logic [2:0] press;
      logic [2:0] rep;
      logic [2:0] rel;
      logic [2:0] lvl;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   nChecks = 0;
   int   nFails  = 0;
   vec_t tbl[64];
   int   tblLen = 0;

   button_repeat_unit_if #(.NUM_BTN(3)) bus ();

   button_repeat_unit #(
      .NUM_BTN        (3),
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .DAS_CYCLES     (10),
      .ARR_CYCLES     (3),
      .ACTIVE_LOW     (1'b0)
   ) dut (
      .clk_25_175(clk),
      .reset     (reset),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [2:0] raw, input logic [2:0] ren, input logic pause);
      bus.btn_raw   = raw;
      bus.repeat_en = ren;
      bus.pause     = pause;
   endtask

   task automatic checkField(input string tag, input int cyc, input string field,
                             input logic [2:0] got, input logic [2:0] want);
      nChecks++;
      if (got !== want) begin
         nFails++;
         $display("[TB] FAIL %s cycle %0d %s: got %b want %b", tag, cyc, field, got, want);
      end
   endtask

   task automatic checkOutput(input string tag, input int cyc, input logic [2:0] press,
                              input logic [2:0] rep, input logic [2:0] rel, input logic [2:0] lvl);
      checkField(tag, cyc, "press",     bus.btn_press,     press);
      checkField(tag, cyc, "is_repeat", bus.btn_is_repeat, rep);
      checkField(tag, cyc, "release",   bus.btn_release,   rel);
      checkField(tag, cyc, "level",     bus.btn_level,     lvl);
   endtask

   task automatic resetDut();
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(3'b000, 3'b000, 1'b0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic addVec(input int cyc, input logic [2:0] raw, input logic [2:0] ren,
                         input logic pause, input logic [2:0] press, input logic [2:0] rep,
                         input logic [2:0] rel, input logic [2:0] lvl);
      tbl[tblLen].cyc   = cyc;
      tbl[tblLen].raw   = raw;
      tbl[tblLen].ren   = ren;
      tbl[tblLen].pause = pause;
      tbl[tblLen].press = press;
      tbl[tblLen].rep   = rep;
      tbl[tblLen].rel   = rel;
      tbl[tblLen].lvl   = lvl;
      tblLen++;
   endtask

   // Sparse table: inputs persist between records, pulses are zero off-record, level carries over.
   task automatic runTable(input string tag);
      int         idx;
      int         last;
      logic [2:0] lvl;
      logic [2:0] press;
      logic [2:0] rep;
      logic [2:0] rel;
      idx  = 0;
      lvl  = 3'b000;
      last = tbl[tblLen-1].cyc;
      resetDut();
      for (int c = 0; c <= last; c++) begin
         press = 3'b000;
         rep   = 3'b000;
         rel   = 3'b000;
         if (idx < tblLen && tbl[idx].cyc == c) begin
            applyStimulus(tbl[idx].raw, tbl[idx].ren, tbl[idx].pause);
            press = tbl[idx].press;
            rep   = tbl[idx].rep;
            rel   = tbl[idx].rel;
            lvl   = tbl[idx].lvl;
            idx++;
         end
         checkOutput(tag, c, press, rep, rel, lvl);
         @(negedge clk);
      end
      tblLen = 0;
   endtask

   initial begin
      logic [2:0] lvl;
      applyStimulus(3'b000, 3'b000, 1'b0);

      // Clean press held with repeat enabled: press at 6, repeats at 16, 19, 22, 25.
      addVec( 0, 3'b001, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
      addVec( 6, 3'b001, 3'b111, 1'b0, 3'b001, 3'b000, 3'b000, 3'b001);
      addVec(16, 3'b001, 3'b111, 1'b0, 3'b001, 3'b001, 3'b000, 3'b001);
      addVec(19, 3'b001, 3'b111, 1'b0, 3'b001, 3'b001, 3'b000, 3'b001);
      addVec(22, 3'b001, 3'b111, 1'b0, 3'b001, 3'b001, 3'b000, 3'b001);
      addVec(25, 3'b001, 3'b111, 1'b0, 3'b001, 3'b001, 3'b000, 3'b001);
      addVec(27, 3'b001, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 3'b001);
      runTable("das_arr");

      // Bouncing btn1 for 20 cycles then held: one press 6 cycles after the last rise.
      for (int k = 0; k <= 10; k++)
         addVec(2 * k, (k % 2 == 0) ? 3'b010 : 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
      addVec(26, 3'b010, 3'b000, 1'b0, 3'b010, 3'b000, 3'b000, 3'b010);
      addVec(34, 3'b010, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 3'b010);
      runTable("bounce");

      // Repeat disabled: single press, release 6 cycles after the raw fall.
      addVec( 0, 3'b001, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
      addVec( 6, 3'b001, 3'b000, 1'b0, 3'b001, 3'b000, 3'b000, 3'b001);
      addVec(50, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 3'b001);
      addVec(56, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b001, 3'b000);
      addVec(60, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
      runTable("no_repeat");

      // Pause seen at edges 12..20 freezes rcnt at 5: repeats move to 25 and 28.
      addVec( 0, 3'b001, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
      addVec( 6, 3'b001, 3'b111, 1'b0, 3'b001, 3'b000, 3'b000, 3'b001);
      addVec(11, 3'b001, 3'b111, 1'b1, 3'b000, 3'b000, 3'b000, 3'b001);
      addVec(20, 3'b001, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 3'b001);
      addVec(25, 3'b001, 3'b111, 1'b0, 3'b001, 3'b001, 3'b000, 3'b001);
      addVec(28, 3'b001, 3'b111, 1'b0, 3'b001, 3'b001, 3'b000, 3'b001);
      addVec(30, 3'b001, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 3'b001);
      runTable("pause");

      // Release of btn0 lands on its due repeat at 22; btn2 pressed in the same cycle.
      addVec( 0, 3'b001, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
      addVec( 6, 3'b001, 3'b111, 1'b0, 3'b001, 3'b000, 3'b000, 3'b001);
      addVec(16, 3'b100, 3'b111, 1'b0, 3'b001, 3'b001, 3'b000, 3'b001);
      addVec(19, 3'b100, 3'b111, 1'b0, 3'b001, 3'b001, 3'b000, 3'b001);
      addVec(22, 3'b100, 3'b111, 1'b0, 3'b100, 3'b000, 3'b001, 3'b100);
      addVec(31, 3'b100, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 3'b100);
      addVec(32, 3'b100, 3'b111, 1'b0, 3'b100, 3'b100, 3'b000, 3'b100);
      runTable("release_wins");

      // Reset pulse while btn0 is repeating, then a fresh press 6 cycles after reset drops.
      resetDut();
      applyStimulus(3'b001, 3'b111, 1'b0);
      lvl = 3'b000;
      for (int c = 0; c <= 20; c++) begin
         if (c == 6) lvl = 3'b001;
         if (c == 20) reset = 1'b1;
         if (c == 6)
            checkOutput("reset_hold", c, 3'b001, 3'b000, 3'b000, lvl);
         else if (c == 16 || c == 19)
            checkOutput("reset_hold", c, 3'b001, 3'b001, 3'b000, lvl);
         else
            checkOutput("reset_hold", c, 3'b000, 3'b000, 3'b000, lvl);
         @(negedge clk);
      end
      reset = 1'b0;
      lvl   = 3'b000;
      for (int c = 21; c <= 30; c++) begin
         if (c == 27) lvl = 3'b001;
         if (c == 27)
            checkOutput("reset_hold", c, 3'b001, 3'b000, 3'b000, lvl);
         else
            checkOutput("reset_hold", c, 3'b000, 3'b000, 3'b000, lvl);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
